mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle control sequencer for the 18-bit core. It steps each instruction through fetch, decode, execute, memory and writeback. It turns the level control flags from the instruction decoder into single-cycle strobes for the PC, IR, register file and data memory, and handshakes with the instruction and data memories. It sits between the decoder and the datapath register enables, and owns the only PC/IR/register-file write strobes in the core.

## Interface
- `OPCODE_WIDTH`, default 4: width of sampled opcode, for debug only.
- `TIMEOUT`, default 16: maximum cycles a memory request may wait for ready; legal range 2–255.
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports (clock and reset first):
- `i_clk`  in  1  core clock; all state changes on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_run`  in  1  level; 1 allows new fetches, 0 parks in IDLE after the current instruction.
- `i_imem_ready`  in  1  instruction memory ack; instruction word valid this cycle.
- `i_dmem_ready`  in  1  data memory ack; read data valid or write accepted this cycle.
- `i_pc_src`, `i_branch`, `i_memRead`, `i_memWrite`, `i_regWrite`  in  1 each  decoder flags, valid in DECODE.
- `i_zero`  in  1  ALU zero flag, valid in EXEC.
- `o_imem_req`  out  1  instruction fetch request.
- `o_ir_load`  out  1  IR load strobe.
- `o_dmem_req`  out  1  data memory request.
- `o_dmem_we`  out  1  data memory write qualifier, valid with `o_dmem_req`.
- `o_reg_we`  out  1  register file write strobe.
- `o_pc_inc`  out  1  PC ← PC+1 strobe.
- `o_pc_load`  out  1  PC ← target strobe.
- `o_state`  out  3  current state encoding.
- `o_busy`  out  1  state ≠ IDLE.
- `o_error`  out  1  sticky timeout flag.
- `o_retired`  out  CNT_WIDTH  retired-instruction count.

## Operation
States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6. Encoding 7 is illegal and recovers to IDLE on the next edge.

"Retire" means: go to FETCH if `i_run`=1, else IDLE. It also increments `o_retired` (wraps modulo 2^CNT_WIDTH).

State behaviour:
- **IDLE:** all strobes 0. Goes to FETCH when `i_run`=1.
- **FETCH:** `o_imem_req`=1 every cycle.
  - On `i_imem_ready`=1: `o_ir_load`=1 that cycle, then go to DECODE.
- **DECODE:** latches the five decoder flags into internal registers, then goes to EXEC. Flags are not resampled later.
- **EXEC:** decided from the latched flags, in this priority order:
  - `pc_src`: `o_pc_load`=1, retire.
  - else `branch`: if `i_zero`=0, `o_pc_load`=1; otherwise `o_pc_inc`=1. Retire.
  - else `memRead` or `memWrite`: go to MEM.
  - else `regWrite`: go to WB.
  - else: `o_pc_inc`=1, retire (NOP).
- **MEM:** `o_dmem_req`=1 and `o_dmem_we`=latched `memWrite`, held every cycle. On `i_dmem_ready`=1:
  - if `memRead`: go to WB.
  - otherwise: `o_pc_inc`=1, retire.
  - If both flags are latched, the read wins and `o_dmem_we`=0.
- **WB:** `o_reg_we`=1 and `o_pc_inc`=1, then retire.
- **ERR:** all strobes and requests 0; `o_error`=1. Only reset leaves ERR.

Wait counter (8 bits):
- Cleared on entry to FETCH or MEM.
- Increments each FETCH/MEM cycle that has no ready.
- If the counter equals TIMEOUT−1 and ready=0, go to ERR on the next edge.
- Ready on that same cycle wins; no error is raised.

Signal timing and rules:
- `o_imem_req`, `o_dmem_req`, `o_dmem_we`, `o_busy` and `o_state` depend only on state and latched flags (Moore).
- `o_ir_load`, `o_pc_inc`, `o_pc_load` and `o_reg_we` are combinational from state, latched flags, ready and `i_zero`. Each is high for exactly one cycle per instruction.
- At most one of `o_pc_inc` and `o_pc_load` is high in any cycle.
- `i_run` is sampled only in IDLE and at retire. Dropping it mid-instruction does not abort the instruction.
- Ready inputs outside the matching state are ignored.

## Timing
- Reset (`i_rst_n`=0, asynchronous):
  - state=IDLE; every output 0, including `o_retired`, `o_error` and `o_state`.
  - The latched flags and the wait counter are cleared.
  - Reset mid-request drops `o_imem_req` and `o_dmem_req` immediately, without waiting for a clock.
- After reset release with `i_run`=1: first edge goes to FETCH, so `o_imem_req` rises one cycle after release.
- Cycles per instruction, with zero-wait memories, FETCH through retire:
  - JMP, BNE, NOP: 3.
  - ADDI, SUBI, R-type: 4.
  - STR: 4.
  - LDR: 5.
- Each memory wait cycle adds 1.
- Back-to-back instructions: FETCH follows the retire cycle directly, with no IDLE bubble while `i_run`=1.

## Test plan
- **R-type:** reset, `i_run`=1, ready tied 1, decoder `regWrite`=1. States run 1,2,3,5,1; `o_reg_we` and `o_pc_inc` high only in WB; `o_retired`=1 after 4 cycles.
- **LDR:** `i_dmem_ready` delayed 3 cycles. Sequence 1,2,3,4,4,4,4,5; `o_dmem_we`=0 throughout; `o_reg_we` pulses once; total 8 cycles.
- **BNE:** with `i_zero`=0, `o_pc_load`=1 in EXEC. With `i_zero`=1, `o_pc_inc`=1 instead. Both take 3 cycles.
- **Timeout:** `i_imem_ready` held 0, TIMEOUT=16. Enters ERR after 16 FETCH cycles; `o_error`=1 and `o_imem_req`=0. With ready asserted on the 16th cycle instead, goes to DECODE with no error.
- **Run drop:** `i_run` dropped during MEM of an STR. The store completes, `o_pc_inc` pulses, state returns to IDLE, `o_busy`=0, and no further `o_imem_req`.
- **Async reset:** `i_rst_n` asserted mid-cycle in MEM. `o_dmem_req`, `o_busy` and `o_retired` go to 0 before the next edge; `o_error` is cleared from ERR. Also, 65536 retired NOPs wrap `o_retired` to 0.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB and issues one-cycle PC/IR/RF strobes.
// Moore requests and state; ready-qualified strobes are combinational. Memory waits are bounded by TIMEOUT.
module mc_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int TIMEOUT      = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    input  logic                 i_imem_ready,
    input  logic                 i_dmem_ready,
    input  logic                 i_pc_src,
    input  logic                 i_branch,
    input  logic                 i_memRead,
    input  logic                 i_memWrite,
    input  logic                 i_regWrite,
    input  logic                 i_zero,
    output logic                 o_imem_req,
    output logic                 o_ir_load,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic                 o_reg_we,
    output logic                 o_pc_inc,
    output logic                 o_pc_load,
    output logic [2:0]           o_state,
    output logic                 o_busy,
    output logic                 o_error,
    output logic [CNT_WIDTH-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [7:0] LP_WAIT_MAX = 8'(TIMEOUT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 255 || OPCODE_WIDTH < 1) begin : g_param_check
        $error("mc_sequencer: TIMEOUT must be 2..255 and OPCODE_WIDTH >= 1");
    end

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_wait;
    logic                 r_pc_src;
    logic                 r_branch;
    logic                 r_mem_rd;
    logic                 r_mem_wr;
    logic                 r_reg_wr;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                 w_retire;
    logic                 w_ir_load;
    logic                 w_pc_inc;
    logic                 w_pc_load;
    logic                 w_reg_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_pc_src  <= 1'b0;
            r_branch  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, so entry to FETCH/MEM always starts at zero.
            if (w_next != r_state) begin
                r_wait <= 8'd0;
            end else if (r_state == S_FETCH || r_state == S_MEM) begin
                r_wait <= r_wait + 8'd1;
            end
            if (r_state == S_DECODE) begin
                r_pc_src <= i_pc_src;
                r_branch <= i_branch;
                r_mem_rd <= i_memRead;
                r_mem_wr <= i_memWrite;
                r_reg_wr <= i_regWrite;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        w_ir_load = 1'b0;
        w_pc_inc  = 1'b0;
        w_pc_load = 1'b0;
        w_reg_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (i_imem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else if (r_wait == LP_WAIT_MAX) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (r_pc_src) begin
                    w_pc_load = 1'b1;
                    w_retire  = 1'b1;
                end else if (r_branch) begin
                    w_pc_load = ~i_zero;
                    w_pc_inc  = i_zero;
                    w_retire  = 1'b1;
                end else if (r_mem_rd || r_mem_wr) begin
                    w_next = S_MEM;
                end else if (r_reg_wr) begin
                    w_next = S_WB;
                end else begin
                    w_pc_inc = 1'b1;
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                if (i_dmem_ready) begin
                    if (r_mem_rd) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_inc = 1'b1;
                        w_retire = 1'b1;
                    end
                end else if (r_wait == LP_WAIT_MAX) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_inc = 1'b1;
                w_retire = 1'b1;
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
        if (w_retire) w_next = i_run ? S_FETCH : S_IDLE;
    end

    assign o_imem_req = (r_state == S_FETCH);
    assign o_dmem_req = (r_state == S_MEM);
    // A latched read overrides a latched write.
    assign o_dmem_we  = (r_state == S_MEM) && r_mem_wr && !r_mem_rd;
    assign o_ir_load  = w_ir_load;
    assign o_pc_inc   = w_pc_inc;
    assign o_pc_load  = w_pc_load;
    assign o_reg_we   = w_reg_we;
    assign o_state    = r_state;
    assign o_busy     = (r_state != S_IDLE);
    assign o_error    = (r_state == S_ERR);
    assign o_retired  = r_retired;

endmodule

// File: tb/tb_mc_sequencer.sv
// Instruction-level reference: each instruction is expanded into its expected per-cycle
// observation list from the flag/ready/zero choices, and a negedge process compares the DUT.
module tb_mc_sequencer;

    localparam int CW  = 10;
    localparam int TMO = 16;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_ERR = 3'd6;

    typedef struct packed {
        logic [2:0]    st;
        logic          imem_req;
        logic          ir_load;
        logic          dmem_req;
        logic          dmem_we;
        logic          reg_we;
        logic          pc_inc;
        logic          pc_load;
        logic          busy;
        logic          error;
        logic [CW-1:0] ret;
    } obs_t;

    logic i_clk = 1'b0;
    logic i_rst_n, i_run, i_imem_ready, i_dmem_ready;
    logic i_pc_src, i_branch, i_memRead, i_memWrite, i_regWrite, i_zero;
    logic o_imem_req, o_ir_load, o_dmem_req, o_dmem_we, o_reg_we, o_pc_inc, o_pc_load;
    logic [2:0] o_state;
    logic o_busy, o_error;
    logic [CW-1:0] o_retired;

    mc_sequencer #(.OPCODE_WIDTH(4), .TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run),
        .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
        .i_pc_src(i_pc_src), .i_branch(i_branch), .i_memRead(i_memRead),
        .i_memWrite(i_memWrite), .i_regWrite(i_regWrite), .i_zero(i_zero),
        .o_imem_req(o_imem_req), .o_ir_load(o_ir_load), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_reg_we(o_reg_we), .o_pc_inc(o_pc_inc),
        .o_pc_load(o_pc_load), .o_state(o_state), .o_busy(o_busy),
        .o_error(o_error), .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    obs_t exp_q[$];
    logic [CW-1:0] m_ret;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = {o_state, o_imem_req, o_ir_load, o_dmem_req, o_dmem_we, o_reg_we,
                 o_pc_inc, o_pc_load, o_busy, o_error, o_retired};
            chk("cycle", 64'(a), 64'(e));
        end
    end

    // One clock of stimulus plus its expectation; inputs irrelevant to the state are randomized.
    // rv: 0/1 drive i_run to that value, 2 randomize it.
    task automatic cyc(input logic [2:0] st, input logic ir, input logic pci, input logic pcl,
                       input logic rwe, input logic dwe, input logic retire, input int rv,
                       input logic imr, input logic dmr, input logic zr, input logic [4:0] fl);
        obs_t e;
        e.st = st;  e.imem_req = (st == ST_FETCH); e.ir_load = ir;
        e.dmem_req = (st == ST_MEM); e.dmem_we = dwe; e.reg_we = rwe;
        e.pc_inc = pci; e.pc_load = pcl; e.busy = (st != ST_IDLE);
        e.error = (st == ST_ERR); e.ret = m_ret;
        i_run        = (rv == 2) ? 1'($urandom) : (rv == 1);
        i_imem_ready = (st == ST_FETCH)  ? imr : 1'($urandom);
        i_dmem_ready = (st == ST_MEM)    ? dmr : 1'($urandom);
        i_zero       = (st == ST_EXEC)   ? zr  : 1'($urandom);
        {i_pc_src, i_branch, i_memRead, i_memWrite, i_regWrite} =
            (st == ST_DECODE) ? fl : 5'($urandom);
        exp_q.push_back(e);
        if (retire) m_ret = m_ret + 1'b1;
        @(posedge i_clk); #1;
    endtask

    // fl = {pc_src, branch, memRead, memWrite, regWrite}; n = cycles from FETCH through retire.
    task automatic run_instr(input logic [4:0] fl, input logic zr, input int iw, input int dw,
                             input logic ra, output int n);
        logic ps, br, mr, mw, rw, dwe;
        int rv;
        {ps, br, mr, mw, rw} = fl;
        dwe = mw & ~mr;
        rv  = ra ? 1 : 0;
        n   = 0;
        for (int i = 0; i < iw; i++) begin
            cyc(ST_FETCH, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0); n++;
        end
        cyc(ST_FETCH, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0); n++;
        cyc(ST_DECODE, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, fl); n++;
        if (ps) begin
            cyc(ST_EXEC, 0, 0, 1, 0, 0, 1, rv, 0, 0, zr, 0); n++;
        end else if (br) begin
            cyc(ST_EXEC, 0, zr, ~zr, 0, 0, 1, rv, 0, 0, zr, 0); n++;
        end else if (mr | mw) begin
            cyc(ST_EXEC, 0, 0, 0, 0, 0, 0, 2, 0, 0, zr, 0); n++;
            for (int i = 0; i < dw; i++) begin
                cyc(ST_MEM, 0, 0, 0, 0, dwe, 0, 2, 0, 0, 0, 0); n++;
            end
            if (mr) begin
                cyc(ST_MEM, 0, 0, 0, 0, dwe, 0, 2, 0, 1, 0, 0); n++;
                cyc(ST_WB, 0, 1, 0, 1, 0, 1, rv, 0, 0, 0, 0); n++;
            end else begin
                cyc(ST_MEM, 0, 1, 0, 0, dwe, 1, rv, 0, 1, 0, 0); n++;
            end
        end else if (rw) begin
            cyc(ST_EXEC, 0, 0, 0, 0, 0, 0, 2, 0, 0, zr, 0); n++;
            cyc(ST_WB, 0, 1, 0, 1, 0, 1, rv, 0, 0, 0, 0); n++;
        end else begin
            cyc(ST_EXEC, 0, 1, 0, 0, 0, 1, rv, 0, 0, zr, 0); n++;
        end
        if (!ra) begin
            int k;
            k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) cyc(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cyc(ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        chk("reset_outputs", 64'({o_state, o_imem_req, o_ir_load, o_dmem_req, o_dmem_we, o_reg_we,
                                  o_pc_inc, o_pc_load, o_busy, o_error, o_retired}), 64'd0);
        @(posedge i_clk); #1;
        m_ret   = '0;
        i_rst_n = 1'b1;
        cyc(ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        logic [4:0] err_exp;
        i_rst_n = 1'b0; i_run = 1'b0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
        i_pc_src = 1'b0; i_branch = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
        i_regWrite = 1'b0; i_zero = 1'b0;
        m_ret = '0;
        repeat (2) @(posedge i_clk);
        #1;
        do_reset();

        // Directed instruction classes with zero-wait memories, cycle counts pinned by hand.
        run_instr(5'b00001, 0, 0, 0, 1, n); chk("cpi_rtype", 64'(n), 64'd4);
        run_instr(5'b00100, 0, 0, 3, 1, n); chk("cpi_ldr_wait3", 64'(n), 64'd8);
        run_instr(5'b01000, 0, 0, 0, 1, n); chk("cpi_bne_z0", 64'(n), 64'd3);
        run_instr(5'b01000, 1, 0, 0, 1, n); chk("cpi_bne_z1", 64'(n), 64'd3);
        run_instr(5'b10000, 0, 0, 0, 1, n); chk("cpi_jmp", 64'(n), 64'd3);
        run_instr(5'b00000, 0, 0, 0, 1, n); chk("cpi_nop", 64'(n), 64'd3);
        run_instr(5'b00010, 0, 0, 0, 1, n); chk("cpi_str", 64'(n), 64'd4);
        run_instr(5'b00110, 0, 0, 1, 1, n); chk("cpi_ld_st_both", 64'(n), 64'd6);
        run_instr(5'b00000, 0, TMO - 1, 0, 1, n); chk("cpi_fetch_last_ready", 64'(n), 64'd18);
        run_instr(5'b00010, 0, 0, TMO - 1, 1, n); chk("cpi_mem_last_ready", 64'(n), 64'd19);
        chk("retired_directed", 64'(o_retired), 64'd10);
        // Store with run dropped: completes, then parks in IDLE.
        run_instr(5'b00010, 0, 1, 2, 0, n);

        // Randomized instruction stream.
        for (int t = 0; t < 300; t++) begin
            int iw, dw;
            iw = ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
            run_instr(5'($urandom), 1'($urandom), iw, dw, ($urandom_range(0, 5) != 0), n);
        end

        // Fetch timeout.
        for (int i = 0; i < TMO; i++) cyc(ST_FETCH, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(ST_ERR, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        err_exp = 5'b10110;
        chk("fetch_timeout_err", 64'({o_error, o_imem_req, o_state}), 64'(err_exp));
        do_reset();

        // Data memory timeout on a store.
        cyc(ST_FETCH, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        cyc(ST_DECODE, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 5'b00010);
        cyc(ST_EXEC, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        for (int i = 0; i < TMO; i++) cyc(ST_MEM, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc(ST_ERR, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        do_reset();

        // Asynchronous reset in the middle of a MEM cycle.
        run_instr(5'b00000, 0, 0, 0, 1, n);
        run_instr(5'b00000, 0, 0, 0, 1, n);
        cyc(ST_FETCH, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        cyc(ST_DECODE, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 5'b00010);
        cyc(ST_EXEC, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        i_dmem_ready = 1'b0;
        #3;
        chk("mem_before_reset", 64'({o_dmem_req, o_dmem_we, o_busy, o_retired}),
            64'({3'b111, CW'(2)}));
        i_rst_n = 1'b0;
        #1;
        chk("mem_async_reset", 64'({o_dmem_req, o_busy, o_state, o_retired}), 64'd0);
        @(posedge i_clk); #1;
        m_ret   = '0;
        i_rst_n = 1'b1;
        cyc(ST_IDLE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Retired counter wraps after 2^CW back-to-back NOPs.
        for (int i = 0; i < (1 << CW); i++) begin
            run_instr(5'b00000, 0, 0, 0, (i != (1 << CW) - 1), n);
        end
        chk("retired_wrap", 64'(o_retired), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
